// File: rtl/lcd_spi_receiver_if.sv
// -----------------------------------------------------------------------------
// lcd_spi_receiver_if
// Byte stream leaving the LCD SPI receiver.
//   m_data    : received byte (FIFO head)
//   m_is_data : A0 level captured with the byte (0 = command, 1 = display data)
//   m_valid   : FIFO head valid
//   m_ready   : consumer accepts the head when m_valid and m_ready are both high
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface lcd_spi_receiver_if;
    logic [7:0] m_data;
    logic       m_is_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_is_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_is_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/lcd_spi_receiver.sv
// -----------------------------------------------------------------------------
// lcd_spi_receiver
// Target-side model of the LCD SPI link. Deserialises SCLK/MOSI/CS_N/A0/RST
// (asynchronous to clk) into bytes tagged as command or display data and
// queues them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   spi_sclk/mosi     : SPI clock (sampled on rising edge) and data, MSB first
//   spi_cs_n          : active-low chip select
//   lcd_a0            : 0 = command, 1 = display data
//   lcd_rst_n         : active-low LCD reset pin
//   stream            : byte stream out (m_data, m_is_data, m_valid, m_ready)
//   fifo_level        : current FIFO occupancy (0..FIFO_DEPTH)
//   overrun           : sticky, a completed byte was dropped on a full FIFO
//   frame_err         : sticky, CS_N released with 1..7 bits shifted
//   lcd_in_reset      : synchronised lcd_rst_n is low
//   clr_status        : pulse clearing overrun/frame_err (a new event wins)
// -----------------------------------------------------------------------------
module lcd_spi_receiver #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_sclk,
    input  logic                         spi_mosi,
    input  logic                         spi_cs_n,
    input  logic                         lcd_a0,
    input  logic                         lcd_rst_n,
    lcd_spi_receiver_if.master           stream,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overrun,
    output logic                         frame_err,
    output logic                         lcd_in_reset,
    input  logic                         clr_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // Pin vector layout and the idle level each synchroniser resets to, so
    // that releasing rst does not look like CS_N or LCD reset asserting.
    localparam int P_SCLK  = 4;
    localparam int P_MOSI  = 3;
    localparam int P_CS_N  = 2;
    localparam int P_A0    = 1;
    localparam int P_RST_N = 0;
    localparam logic [4:0] PIN_IDLE = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LCDRST
    } state_t;

    // ---------------- synchronisers ----------------
    logic [SYNC_STAGES-1:0][4:0] sync_reg;
    logic [4:0]                  pins_s;
    logic                        sclk_d_reg;
    logic                        sclk_s, mosi_s, cs_s, a0_s, lcd_rst_s;
    logic                        rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= {SYNC_STAGES{PIN_IDLE}};
            sclk_d_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0],
                           {spi_sclk, spi_mosi, spi_cs_n, lcd_a0, lcd_rst_n}};
            sclk_d_reg <= sclk_s;
        end
    end

    assign pins_s    = sync_reg[SYNC_STAGES-1];
    assign sclk_s    = pins_s[P_SCLK];
    assign mosi_s    = pins_s[P_MOSI];
    assign cs_s      = pins_s[P_CS_N];
    assign a0_s      = pins_s[P_A0];
    assign lcd_rst_s = pins_s[P_RST_N];
    assign rise      = sclk_s & ~sclk_d_reg;

    // ---------------- deserialiser FSM ----------------
    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] byte_data_reg;
    logic       byte_is_data_reg;
    logic       byte_done_reg;
    logic       lcd_in_reset_reg;
    logic       frame_evt;

    // A partial byte is a framing error only when CS_N ends the transfer;
    // an LCD reset discarding it takes priority and is not an error.
    assign frame_evt = (state_reg == ST_SHIFT) && lcd_rst_s && cs_s &&
                       (bit_cnt_reg != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= 3'd0;
            shift_reg        <= 8'd0;
            byte_data_reg    <= 8'd0;
            byte_is_data_reg <= 1'b0;
            byte_done_reg    <= 1'b0;
            lcd_in_reset_reg <= 1'b0;
        end else begin
            byte_done_reg    <= 1'b0;
            lcd_in_reset_reg <= ~lcd_rst_s;
            if (!lcd_rst_s) begin
                state_reg   <= ST_LCDRST;
                bit_cnt_reg <= 3'd0;
                shift_reg   <= 8'd0;
            end else begin
                case (state_reg)
                    ST_LCDRST: state_reg <= ST_IDLE;
                    ST_IDLE: begin
                        if (!cs_s) state_reg <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (cs_s) begin
                            state_reg   <= ST_IDLE;
                            bit_cnt_reg <= 3'd0;
                            shift_reg   <= 8'd0;
                        end else if (rise) begin
                            shift_reg <= {shift_reg[6:0], mosi_s};
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg      <= 3'd0;
                                byte_done_reg    <= 1'b1;
                                byte_data_reg    <= {shift_reg[6:0], mosi_s};
                                byte_is_data_reg <= a0_s;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- output FIFO ----------------
    // Storage RAM plus a head register. fifo_level counts both, so a byte
    // sits in the RAM for one cycle before it is presented on m_data.
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] mem_cnt_reg, level_reg;
    logic [7:0]    m_data_reg;
    logic          m_is_data_reg, m_valid_reg;
    logic          overrun_reg, frame_err_reg;
    logic          full, pop, push_ok, load, overrun_evt;

    assign full        = (level_reg == LW'(FIFO_DEPTH));
    assign pop         = m_valid_reg & stream.m_ready;
    // A pop in the same cycle frees the slot, so full + pop + push succeeds.
    assign push_ok     = byte_done_reg & (~full | pop);
    assign overrun_evt = byte_done_reg & full & ~pop;
    assign load        = (mem_cnt_reg != '0) & (~m_valid_reg | pop);

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr_reg] <= {byte_is_data_reg, byte_data_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            level_reg     <= '0;
            m_data_reg    <= 8'd0;
            m_is_data_reg <= 1'b0;
            m_valid_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (load) begin
                {m_is_data_reg, m_data_reg} <= mem[rd_ptr_reg];
                rd_ptr_reg                  <= rd_ptr_reg + AW'(1);
                m_valid_reg                 <= 1'b1;
            end else if (pop) begin
                m_valid_reg <= 1'b0;
            end
            mem_cnt_reg   <= mem_cnt_reg + LW'(push_ok) - LW'(load);
            level_reg     <= level_reg + LW'(push_ok) - LW'(pop);
            overrun_reg   <= overrun_evt | (overrun_reg & ~clr_status);
            frame_err_reg <= frame_evt | (frame_err_reg & ~clr_status);
        end
    end

    assign stream.m_data    = m_data_reg;
    assign stream.m_is_data = m_is_data_reg;
    assign stream.m_valid   = m_valid_reg;
    assign fifo_level       = level_reg;
    assign overrun          = overrun_reg;
    assign frame_err        = frame_err_reg;
    assign lcd_in_reset     = lcd_in_reset_reg;

endmodule
